// File: rtl/mod3_serial_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mod3_serial_tx
// Brief    : MSB-first serializer with a per-bit "prefix divisible by 3" flag
// Revision : 1.0 - initial release
// ============================================================================
module mod3_serial_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             first,
    output logic             last,
    output logic             div3
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       rem_q;
    logic [1:0]       rem_d;
    logic             bit_d;
    logic             out_q;
    logic             out_valid_q;
    logic             first_q;
    logic             last_q;
    logic             div3_q;

    // The register is shifted left after each bit, so the next bit always
    // sits just below the MSB position.
    always_comb begin
        bit_d = shreg_q[WIDTH-2];
        rem_d = 2'd0;
        case (rem_q)
            2'd0:    rem_d = bit_d ? 2'd1 : 2'd0;
            2'd1:    rem_d = bit_d ? 2'd0 : 2'd2;
            2'd2:    rem_d = bit_d ? 2'd2 : 2'd1;
            default: rem_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            rem_q       <= 2'd0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            div3_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && !abort) begin
                        state_q     <= SHIFT;
                        shreg_q     <= data_in;
                        cnt_q       <= CW'(WIDTH-1);
                        rem_q       <= {1'b0, data_in[WIDTH-1]};
                        out_q       <= data_in[WIDTH-1];
                        out_valid_q <= 1'b1;
                        first_q     <= 1'b1;
                        last_q      <= 1'b0;
                        div3_q      <= ~data_in[WIDTH-1];
                    end else begin
                        out_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        first_q     <= 1'b0;
                        last_q      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort || (cnt_q == '0)) begin
                        // div3 keeps the last shown result across the gap
                        state_q     <= IDLE;
                        out_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        first_q     <= 1'b0;
                        last_q      <= 1'b0;
                        if (abort) begin
                            rem_q <= 2'd0;
                        end
                    end else begin
                        shreg_q     <= shreg_q << 1;
                        cnt_q       <= cnt_q - 1'b1;
                        rem_q       <= rem_d;
                        out_q       <= bit_d;
                        out_valid_q <= 1'b1;
                        first_q     <= 1'b0;
                        last_q      <= (cnt_q == CW'(1));
                        div3_q      <= (rem_d == 2'd0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign first     = first_q;
    assign last      = last_q;
    assign div3      = div3_q;

endmodule
`default_nettype wire

// File: tb/tb_mod3_serial_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mod3_serial_tx
// Brief    : Self-checking bench for mod3_serial_tx against a frame-level model
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod3_serial_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_in;
    logic         abort;
    logic         out;
    logic         out_valid;
    logic         first;
    logic         last;
    logic         div3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mod3_serial_tx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .abort     (abort),
        .out       (out),
        .out_valid (out_valid),
        .first     (first),
        .last      (last),
        .div3      (div3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Prefix of the first n bits (MSB first) of w, tested for divisibility by 3.
    function automatic logic pdiv3(input logic [W-1:0] w, input int n);
        int unsigned v;
        v = 32'(w) >> (W - n);
        return (v % 3) == 0;
    endfunction

    // Frame-level model: busy while a frame is on the line, n = bits shown.
    logic         m_busy = 1'b0;
    logic [W-1:0] m_word = '0;
    int           m_n    = 0;
    logic         m_div3 = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_word <= '0;
            m_n    <= 0;
            m_div3 <= 1'b1;
        end else if (m_busy && (abort || m_n == W)) begin
            m_busy <= 1'b0;
            m_div3 <= pdiv3(m_word, m_n);
        end else if (m_busy) begin
            m_n <= m_n + 1;
        end else if (in_valid && !abort) begin
            m_busy <= 1'b1;
            m_word <= data_in;
            m_n    <= 1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  in_ready,  !m_busy);
        chk("out_valid", out_valid, m_busy);
        chk("out",   out,   m_busy ? m_word[W-m_n] : 1'b0);
        chk("first", first, m_busy && (m_n == 1));
        chk("last",  last,  m_busy && (m_n == W));
        chk("div3",  div3,  m_busy ? pdiv3(m_word, m_n) : m_div3);
    end

    // Offer w until accepted; returns 2 ns after the accepting edge.
    task automatic send(input logic [W-1:0] w);
        logic rdy;
        bit   done;
        done     = 1'b0;
        in_valid = 1'b1;
        data_in  = w;
        for (int k = 0; k < 50 && !done; k++) begin
            rdy = in_ready;
            @(posedge clk);
            #2;
            if (rdy) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout actual=no_accept required=accept t=%0t", $time);
        end
    endtask

    task automatic frame_lit(input logic [W-1:0] w, input logic [W-1:0] exp_div);
        send(w);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("lit_out",   out,   w[W-1-i]);
            chk("lit_div3",  div3,  exp_div[W-1-i]);
            chk("lit_first", first, i == 0);
            chk("lit_last",  last,  i == W - 1);
        end
        @(negedge clk);
        chk("lit_end_valid", out_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts[$];
        rst_n    = 1'b0;
        in_valid = 1'b0;
        abort    = 1'b0;
        data_in  = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", in_ready,  1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_div3",  div3,      1'b1);

        chk("model182_p6", pdiv3(8'd182, 6), 1'b1);
        chk("model182_p5", pdiv3(8'd182, 5), 1'b0);
        frame_lit(8'hB6, 8'b0000_0100);
        frame_lit(8'hFF, 8'b0101_0101);
        repeat (3) @(negedge clk);
        chk("ff_div3_hold", div3, 1'b1);
        frame_lit(8'h00, 8'b1111_1111);
        frame_lit(8'h01, 8'b1111_1110);

        // Asynchronous reset in the middle of a frame
        send(8'h5A);
        @(posedge clk);
        #2;
        chk("ar_midframe", out_valid, 1'b1);
        rst_n = 1'b0;
        #0.5;
        chk("ar_out",   out,       1'b0);
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_first", first,     1'b0);
        chk("ar_last",  last,      1'b0);
        chk("ar_div3",  div3,      1'b1);
        #0.5 rst_n = 1'b1;
        #1;
        chk("ar_ready", in_ready, 1'b1);

        // Back-to-back frames with the word toggling every cycle
        @(posedge clk);
        #2 in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            data_in = i[0] ? 8'h3C : 8'hA5;
            @(negedge clk);
            if (first) starts.push_back(cyc);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        chk("b2b_nframes", starts.size() >= 3, 1'b1);
        if (starts.size() >= 3) begin
            chk("b2b_gap1", starts[1] - starts[0], 9);
            chk("b2b_gap2", starts[2] - starts[1], 9);
        end
        repeat (10) @(posedge clk);
        #2;

        // Abort during the third bit, then abort racing a request in IDLE
        send(8'hC3);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk);
        #2 abort = 1'b0;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_ready", in_ready,  1'b1);
        abort    = 1'b1;
        in_valid = 1'b1;
        data_in  = 8'h77;
        @(posedge clk);
        #2;
        chk("abort_idle_valid", out_valid, 1'b0);
        chk("abort_idle_ready", in_ready,  1'b1);
        abort    = 1'b0;
        in_valid = 1'b0;

        // Randomised traffic with occasional abort and asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            in_valid = ($urandom_range(0, 9) < 7);
            abort    = ($urandom_range(0, 24) == 0);
            data_in  = W'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
